// File: rtl/baccarat_pkg.sv
// ---------------------------------------------------------------------------
// baccarat_pkg
//   Shared types, rank constants and scoring helpers for the baccarat
//   hand datapath.
//   - card_t      : 4-bit card rank, 0 = empty slot, 1 = A ... 13 = K
//   - card_value  : baccarat point value of a rank (0..9)
//   - score3      : hand score of three ranks, (sum of values) mod 10
// ---------------------------------------------------------------------------
package baccarat_pkg;

    typedef logic [3:0] card_t;

    localparam card_t RANK_EMPTY = 4'd0;
    localparam card_t RANK_ACE   = 4'd1;
    localparam card_t RANK_NINE  = 4'd9;
    localparam card_t RANK_KING  = 4'd13;

    localparam int NUM_SLOTS = 6;

    // Ace..9 count face value; 10 and court cards count zero; empty is zero.
    function automatic logic [3:0] card_value(input card_t c);
        return (c >= RANK_ACE && c <= RANK_NINE) ? c : 4'd0;
    endfunction

    // Sum fits in 5 bits (max 27), so two conditional subtractions replace
    // a general modulo.
    function automatic logic [3:0] score3(input card_t a, input card_t b, input card_t c);
        logic [4:0] sum;
        sum = {1'b0, card_value(a)} + {1'b0, card_value(b)} + {1'b0, card_value(c)};
        if (sum >= 5'd20)
            sum = sum - 5'd20;
        else if (sum >= 5'd10)
            sum = sum - 5'd10;
        return sum[3:0];
    endfunction

endpackage

// File: rtl/card_shoe.sv
// ---------------------------------------------------------------------------
// card_shoe
//   Card source for the hand datapath. Advances on every rising edge of
//   slow_clock while not in reset; the current card is always 1..13.
//   Build option SHOE_LFSR_EN:
//     defined   - 8-bit Galois LFSR (x^8 + x^6 + x^5 + x^4 + 1) seeded with
//                 SHOE_SEED; card = (lfsr mod 13) + 1
//     undefined - counter 1, 2, ..., 13, 1, ... starting at SHOE_START
// Ports
//   slow_clock  in   1  clock
//   resetb      in   1  asynchronous reset, active high
//   card        out  4  current shoe card
// ---------------------------------------------------------------------------
module card_shoe
    import baccarat_pkg::*;
#(
`ifdef SHOE_LFSR_EN
    parameter logic [7:0] SHOE_SEED  = 8'hA5
`else
    parameter card_t      SHOE_START = 4'd1
`endif
) (
    input  logic  slow_clock,
    input  logic  resetb,
    output card_t card
);

`ifdef SHOE_LFSR_EN
    logic [7:0] r_lfsr;
    logic [7:0] w_lfsr_next;

    // Right-shifting Galois form: feedback bit XORs mask 0xB8 (taps 8,6,5,4).
    assign w_lfsr_next = {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, matching the hardware.
    always_ff @(posedge slow_clock or posedge resetb) begin
        if (resetb)
            r_lfsr <= SHOE_SEED;
        else
            r_lfsr <= w_lfsr_next;
    end

    assign card = 4'((r_lfsr % 8'd13) + 8'd1);
`else
    card_t r_card;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, matching the hardware.
    always_ff @(posedge slow_clock or posedge resetb) begin
        if (resetb)
            r_card <= SHOE_START;
        else if (r_card == RANK_KING)
            r_card <= RANK_ACE;
        else
            r_card <= r_card + 4'd1;
    end

    assign card = r_card;
`endif

endmodule

// File: rtl/card_hand_datapath.sv
// ---------------------------------------------------------------------------
// card_hand_datapath
//   Holds the player and dealer hands for the baccarat deal controller.
//   A single load strobe into an empty slot captures the current shoe card;
//   simultaneous strobes or a strobe into a filled slot change nothing and
//   set the sticky proto_err flag. Card and score outputs are combinational
//   from the slot registers.
//   Build option SHOE_LFSR_EN selects the LFSR shoe (see card_shoe).
// Ports
//   slow_clock          in   1  clock
//   resetb              in   1  asynchronous reset, active high
//   load_pcard1..3      in   1  capture shoe card into player slot 1..3
//   load_dcard1..3      in   1  capture shoe card into dealer slot 1..3
//   pcard1..3           out  4  player ranks (0 = empty)
//   dcard1..3           out  4  dealer ranks (0 = empty)
//   pscore, dscore      out  4  hand scores 0..9
//   cards_dealt         out  3  filled slot count 0..6
//   proto_err           out  1  sticky protocol-violation flag
// ---------------------------------------------------------------------------
module card_hand_datapath
    import baccarat_pkg::*;
#(
`ifdef SHOE_LFSR_EN
    parameter logic [7:0] SHOE_SEED  = 8'hA5
`else
    parameter card_t      SHOE_START = 4'd1
`endif
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic [2:0] cards_dealt,
    output logic       proto_err
);

    card_t                 w_shoe_card;
    logic [NUM_SLOTS-1:0]  w_load;
    logic                  w_one_hot;
    logic                  w_target_empty;
    logic                  w_legal;
    logic                  w_violation;

    card_t                 r_slot [NUM_SLOTS];
    logic [2:0]            r_cards_dealt;
    logic                  r_proto_err;

    card_shoe #(
`ifdef SHOE_LFSR_EN
        .SHOE_SEED  (SHOE_SEED)
`else
        .SHOE_START (SHOE_START)
`endif
    ) u_shoe (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .card       (w_shoe_card)
    );

    // Slot order: player 1..3 in bits 0..2, dealer 1..3 in bits 3..5.
    assign w_load = {load_dcard3, load_dcard2, load_dcard1,
                     load_pcard3, load_pcard2, load_pcard1};

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign w_one_hot = (w_load != '0) && ((w_load & (w_load - 6'd1)) == '0);

    // Only meaningful when w_one_hot holds: tells whether the addressed slot is empty.
    // NOTE: combinational outputs get a default before the loop so no latch is inferred.
    always_comb begin
        w_target_empty = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_load[i] && r_slot[i] == RANK_EMPTY)
                w_target_empty = 1'b1;
        end
    end

    assign w_legal     = w_one_hot && w_target_empty;
    assign w_violation = (w_load != '0) && !w_legal;

    // NOTE: the slot array is reset because rank 0 is the "empty" marker the
    // overwrite check depends on.
    always_ff @(posedge slow_clock or posedge resetb) begin
        if (resetb) begin
            for (int i = 0; i < NUM_SLOTS; i++)
                r_slot[i] <= RANK_EMPTY;
            r_cards_dealt <= 3'd0;
            r_proto_err   <= 1'b0;
        end else begin
            if (w_legal) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (w_load[i])
                        r_slot[i] <= w_shoe_card;
                end
                r_cards_dealt <= r_cards_dealt + 3'd1;
            end
            if (w_violation)
                r_proto_err <= 1'b1;
        end
    end

    assign pcard1      = r_slot[0];
    assign pcard2      = r_slot[1];
    assign pcard3      = r_slot[2];
    assign dcard1      = r_slot[3];
    assign dcard2      = r_slot[4];
    assign dcard3      = r_slot[5];
    assign pscore      = score3(r_slot[0], r_slot[1], r_slot[2]);
    assign dscore      = score3(r_slot[3], r_slot[4], r_slot[5]);
    assign cards_dealt = r_cards_dealt;
    assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_card_hand_datapath.sv
// ---------------------------------------------------------------------------
// tb_card_hand_datapath
//   Directed bench for card_hand_datapath. Inputs change between edges,
//   outputs are sampled 1 ns after the rising edge. Counter-shoe scenarios
//   run in the default build; the LFSR scenarios run with SHOE_LFSR_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_card_hand_datapath;

    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] P1   = 6'b000001;
    localparam logic [5:0] P2   = 6'b000010;
    localparam logic [5:0] P3   = 6'b000100;
    localparam logic [5:0] D1   = 6'b001000;
    localparam logic [5:0] D2   = 6'b010000;
    localparam logic [5:0] D3   = 6'b100000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] ld  = '0;
    logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
    logic [3:0] pscore, dscore;
    logic [2:0] cards_dealt;
    logic       proto_err;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    card_hand_datapath dut (
        .slow_clock  (clk),
        .resetb      (rst),
        .load_pcard1 (ld[0]),
        .load_pcard2 (ld[1]),
        .load_pcard3 (ld[2]),
        .load_dcard1 (ld[3]),
        .load_dcard2 (ld[4]),
        .load_dcard3 (ld[5]),
        .pcard1      (pcard1),
        .pcard2      (pcard2),
        .pcard3      (pcard3),
        .dcard1      (dcard1),
        .dcard2      (dcard2),
        .dcard3      (dcard3),
        .pscore      (pscore),
        .dscore      (dscore),
        .cards_dealt (cards_dealt),
        .proto_err   (proto_err)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Apply strobes for exactly one rising edge, then sample 1 ns later.
    task automatic tick(input logic [5:0] strobes);
        ld = strobes;
        @(posedge clk);
        #1;
        ld = NONE;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            tick(NONE);
    endtask

    // Assert reset between edges, release on the next falling edge; shoe is
    // at its start value afterwards.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_p1"}, {4'd0, pcard1}, 8'd0);
        check({tag, "_p2"}, {4'd0, pcard2}, 8'd0);
        check({tag, "_p3"}, {4'd0, pcard3}, 8'd0);
        check({tag, "_d1"}, {4'd0, dcard1}, 8'd0);
        check({tag, "_d2"}, {4'd0, dcard2}, 8'd0);
        check({tag, "_d3"}, {4'd0, dcard3}, 8'd0);
        check({tag, "_ps"}, {4'd0, pscore}, 8'd0);
        check({tag, "_ds"}, {4'd0, dscore}, 8'd0);
        check({tag, "_cnt"}, {5'd0, cards_dealt}, 8'd0);
        check({tag, "_err"}, {7'd0, proto_err}, 8'd0);
    endtask

`ifdef SHOE_LFSR_EN
    logic [3:0] seq [200];
`endif

    initial begin
        // Reset state; edges during reset are ignored.
        #2;
        tick(P1);
        check_all_zero("rst");
        do_reset();
        check_all_zero("rst_rel");

`ifndef SHOE_LFSR_EN
        // 1. One idle edge (shoe 1 -> 2), then four loads: cards 2, 3, 4, 5.
        idle(1);
        tick(P1);
        check("t1_p1_latency", {4'd0, pcard1}, 8'd2);
        tick(D1);
        tick(P2);
        tick(D2);
        check("t1_p1", {4'd0, pcard1}, 8'd2);
        check("t1_d1", {4'd0, dcard1}, 8'd3);
        check("t1_p2", {4'd0, pcard2}, 8'd4);
        check("t1_d2", {4'd0, dcard2}, 8'd5);
        check("t1_ps", {4'd0, pscore}, 8'd6);
        check("t1_ds", {4'd0, dscore}, 8'd8);
        check("t1_cnt", {5'd0, cards_dealt}, 8'd4);
        // Third cards 6 and 7: sums 12 and 15 reduce mod 10; all six slots full.
        tick(P3);
        check("t1_p3", {4'd0, pcard3}, 8'd6);
        check("t1_ps_mod", {4'd0, pscore}, 8'd2);
        tick(D3);
        check("t1_d3", {4'd0, dcard3}, 8'd7);
        check("t1_ds_mod", {4'd0, dscore}, 8'd5);
        check("t1_cnt_full", {5'd0, cards_dealt}, 8'd6);
        check("t1_err", {7'd0, proto_err}, 8'd0);

        // 2. Shoe 1 -> 10 in 9 idle edges; 10 to pcard1, K to pcard2, 9 to pcard3.
        do_reset();
        idle(9);
        tick(P1);
        check("t2_p1_ten", {4'd0, pcard1}, 8'd10);
        check("t2_ps_ten", {4'd0, pscore}, 8'd0);
        idle(2);
        tick(P2);
        check("t2_p2_king", {4'd0, pcard2}, 8'd13);
        check("t2_ps_face", {4'd0, pscore}, 8'd0);
        idle(8);
        tick(P3);
        check("t2_p3_raw", {4'd0, pcard3}, 8'd9);
        check("t2_ps", {4'd0, pscore}, 8'd9);
        check("t2_cnt", {5'd0, cards_dealt}, 8'd3);

        // 3. Shoe sits at 10; 13 idle edges bring it back to 10.
        idle(13);
        tick(D1);
        check("t3_wrap", {4'd0, dcard1}, 8'd10);
        check("t3_cnt", {5'd0, cards_dealt}, 8'd4);

        // 4. Two strobes at one edge: nothing loads, error sticks.
        do_reset();
        tick(P1 | D1);
        check("t4_p1", {4'd0, pcard1}, 8'd0);
        check("t4_d1", {4'd0, dcard1}, 8'd0);
        check("t4_cnt", {5'd0, cards_dealt}, 8'd0);
        check("t4_err", {7'd0, proto_err}, 8'd1);
        tick(P1);
        check("t4_legal_p1", {4'd0, pcard1}, 8'd2);
        check("t4_legal_cnt", {5'd0, cards_dealt}, 8'd1);
        check("t4_err_sticky", {7'd0, proto_err}, 8'd1);

        // 5. Reload a filled slot.
        do_reset();
        tick(P1);
        check("t5_p1", {4'd0, pcard1}, 8'd1);
        check("t5_err_clean", {7'd0, proto_err}, 8'd0);
        tick(P1);
        check("t5_p1_kept", {4'd0, pcard1}, 8'd1);
        check("t5_cnt", {5'd0, cards_dealt}, 8'd1);
        check("t5_err", {7'd0, proto_err}, 8'd1);

        // 6. Mid-hand reset between edges clears at once; strobes ignored in reset.
        tick(D1);
        check("t6_pre_d1", {4'd0, dcard1}, 8'd3);
        rst = 1'b1;
        #1;
        check_all_zero("t6_async");
        tick(P1);
        check("t6_hold_p1", {4'd0, pcard1}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(P1);
        check("t6_restart_p1", {4'd0, pcard1}, 8'd1);
        check("t6_restart_cnt", {5'd0, cards_dealt}, 8'd1);
`else
        // LFSR shoe: card after i idle edges from reset, for i = 0..199.
        for (int i = 0; i < 200; i++) begin
            do_reset();
            idle(i);
            tick(P1);
            seq[i] = pcard1;
            check("lfsr_range", {7'd0, (pcard1 >= 4'd1 && pcard1 <= 4'd13)}, 8'd1);
        end
        check("lfsr_first", {4'd0, seq[0]}, 8'((8'hA5 % 8'd13) + 8'd1));
        // The same sequence must follow every reset.
        for (int i = 0; i < 20; i++) begin
            do_reset();
            idle(i);
            tick(P1);
            check("lfsr_repeat", {4'd0, pcard1}, {4'd0, seq[i]});
        end
        rst = 1'b1;
        #1;
        check_all_zero("lfsr_async");
        rst = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
